// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Request/result bundle for serial_subtractor. The bin signal
//            exists only when SERIAL_SUB_BORROW_IN_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BORROW_IN_EN
   logic             bin;
`endif
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             busy;
   logic             done;

`ifdef SERIAL_SUB_BORROW_IN_EN
   modport master (output start, a, b, bin, input diff, bout, busy, done);
   modport slave  (input start, a, b, bin, output diff, bout, busy, done);
`else
   modport master (output start, a, b, input diff, bout, busy, done);
   modport slave  (input start, a, b, output diff, bout, busy, done);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial LSB-first subtractor, diff = a - b (- bin), one bit
//            per clock. Define SERIAL_SUB_BORROW_IN_EN to add the bin input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic             borrow;
   logic [CW-1:0]    cnt;

   logic seed;
   logic d1, b1, d, b2, borrow_nxt;
   logic last_bit;

`ifdef SERIAL_SUB_BORROW_IN_EN
   assign seed = bus.bin;
`else
   assign seed = 1'b0;
`endif

   // Full subtractor built from two cascaded half subtractors
   assign d1         = sa[0] ^ sb[0];
   assign b1         = ~sa[0] & sb[0];
   assign d          = d1 ^ borrow;
   assign b2         = ~d1 & borrow;
   assign borrow_nxt = b1 | b2;
   assign last_bit   = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_bit)  state_nxt = DONE;
         DONE:    state_nxt = bus.start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         res      <= '0;
         borrow   <= 1'b0;
         cnt      <= '0;
         bus.diff <= '0;
         bus.bout <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state    <= state_nxt;
         // busy/done are registered copies of the next state so outputs stay flop-driven
         bus.busy <= (state_nxt == RUN);
         bus.done <= (state_nxt == DONE);
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  sa       <= bus.a;
                  sb       <= bus.b;
                  res      <= '0;
                  borrow   <= seed;
                  cnt      <= '0;
                  bus.diff <= '0;
                  bus.bout <= 1'b0;
               end
            end
            RUN: begin
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               res    <= {d, res[WIDTH-1:1]};
               borrow <= borrow_nxt;
               if (last_bit) begin
                  bus.diff <= {d, res[WIDTH-1:1]};
                  bus.bout <= borrow_nxt;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (vector table plus
//            scoreboard queue, with hand-written multi-cycle sequences).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;
   localparam int WIDTH = 8;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
   } vec_t;

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   int   cyc = 0;
   exp_t sb_q[$];
   vec_t vecs[$];

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic bin);
      bus.a = a;
      bus.b = b;
`ifdef SERIAL_SUB_BORROW_IN_EN
      bus.bin = bin;
`else
      if (bin) $display("note: bin ignored in this build");
`endif
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!bus.done && n < 40) begin
         tick();
         n++;
      end
   endtask

   // Scoreboard: every done pulse pops one expected result
   always @(negedge clk) begin
      if (bus.done) begin
         exp_t e;
         done_cnt++;
         check("busy_with_done", 32'(bus.busy), 32'd0);
         if (sb_q.size() == 0) begin
            check("done_with_empty_queue", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check("diff", 32'(bus.diff), 32'(e.diff));
            check("bout", 32'(bus.bout), 32'(e.bout));
         end
      end
   end

   task automatic run_op(input vec_t v);
      int lat;
      int bc;
      set_ops(v.a, v.b, v.bin);
      bus.start = 1'b1;
      tick();
      sb_q.push_back('{diff: v.diff, bout: v.bout});
      bus.start = 1'b0;
      lat = 1;
      bc  = bus.busy ? 1 : 0;
      while (!bus.done && lat < 40) begin
         tick();
         lat++;
         if (bus.busy) bc++;
      end
      check("latency", 32'(lat), 32'(WIDTH + 1));
      check("busy_cycles", 32'(bc), 32'(WIDTH));
      tick();
      check("done_clear", 32'(bus.done), 32'd0);
      check("diff_hold", 32'(bus.diff), 32'(v.diff));
      check("bout_hold", 32'(bus.bout), 32'(v.bout));
   endtask

   initial begin
      int   n;
      int   d0;
      int   c1;
      logic [8:0] m;
      vec_t v;

      vecs.push_back('{a: 8'h5A, b: 8'h23, bin: 1'b0, diff: 8'h37, bout: 1'b0});
      vecs.push_back('{a: 8'h10, b: 8'h20, bin: 1'b0, diff: 8'hF0, bout: 1'b1});
      vecs.push_back('{a: 8'h00, b: 8'h00, bin: 1'b0, diff: 8'h00, bout: 1'b0});
      vecs.push_back('{a: 8'hFF, b: 8'h01, bin: 1'b0, diff: 8'hFE, bout: 1'b0});
      vecs.push_back('{a: 8'h00, b: 8'hFF, bin: 1'b0, diff: 8'h01, bout: 1'b1});
`ifdef SERIAL_SUB_BORROW_IN_EN
      vecs.push_back('{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1});
      vecs.push_back('{a: 8'h10, b: 8'h0F, bin: 1'b1, diff: 8'h00, bout: 1'b0});
`endif
      for (int i = 0; i < 4; i++) begin
         v.a   = 8'($urandom_range(0, 255));
         v.b   = 8'($urandom_range(0, 255));
`ifdef SERIAL_SUB_BORROW_IN_EN
         v.bin = 1'($urandom_range(0, 1));
`else
         v.bin = 1'b0;
`endif
         m      = {1'b0, v.a} - {1'b0, v.b} - {8'd0, v.bin};
         v.diff = m[7:0];
         v.bout = m[8];
         vecs.push_back(v);
      end

      rst       = 1'b1;
      bus.start = 1'b0;
      set_ops(8'h00, 8'h00, 1'b0);
      repeat (3) tick();
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_bout", 32'(bus.bout), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      tick();

      foreach (vecs[i]) begin
         run_op(vecs[i]);
         tick();
      end

      // Start re-pulsed during RUN must be ignored
      set_ops(8'h5A, 8'h23, 1'b0);
      bus.start = 1'b1;
      tick();
      sb_q.push_back('{diff: 8'h37, bout: 1'b0});
      bus.start = 1'b0;
      d0 = done_cnt;
      tick();
      tick();
      set_ops(8'h00, 8'hFF, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("restart_busy", 32'(bus.busy), 32'd1);
      wait_done(n);
      check("restart_wait", 32'(n), 32'(WIDTH - 3));
      repeat (12) tick();
      check("restart_single_done", 32'(done_cnt - d0), 32'd1);
      check("restart_q_empty", 32'(sb_q.size()), 32'd0);

      // Reset in the 4th RUN cycle aborts with no done pulse
      set_ops(8'h5A, 8'h23, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_diff", 32'(bus.diff), 32'd0);
      check("abort_bout", 32'(bus.bout), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      d0 = done_cnt;
      repeat (12) tick();
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_op('{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0});
      tick();

      // Start held high: back-to-back operations every WIDTH+1 cycles
      set_ops(8'h05, 8'h03, 1'b0);
      bus.start = 1'b1;
      tick();
      sb_q.push_back('{diff: 8'h02, bout: 1'b0});
      set_ops(8'h03, 8'h05, 1'b0);
      wait_done(n);
      check("b2b_first_wait", 32'(n), 32'(WIDTH));
      c1 = cyc;
      tick();
      sb_q.push_back('{diff: 8'hFE, bout: 1'b1});
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_cleared_diff", 32'(bus.diff), 32'd0);
      wait_done(n);
      check("b2b_period", 32'(cyc - c1), 32'(WIDTH + 1));
      repeat (3) tick();
      check("final_q_empty", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing diff = a − b (− bin) LSB-first, one bit per clock. It is the sequential consumer of the half-subtractor cell. Two half-subtractor stages plus a borrow flip-flop form the per-bit full subtractor. It serves as the low-area subtraction stage wherever throughput of one result per WIDTH+1 cycles is acceptable.

## Interface
- WIDTH, default 8, operand/result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk, accepted only in IDLE or DONE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; present only when SERIAL_SUB_BORROW_IN_EN is defined.
- diff  output  WIDTH  result; registered, holds until the next accepted start.
- bout  output  1  final borrow out; 1 when a < b (+ bin), unsigned.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result valid.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE with start=1 on an edge:
  - load shift registers sa←a and sb←b;
  - load the borrow flop with the seed (0, or bin with the macro);
  - clear the bit counter to 0;
  - clear diff and bout to 0;
  - go to RUN.
- DONE with start=0 → IDLE.
- Each RUN edge, using x=sa[0], y=sb[0], c=borrow:
  - first half subtractor: d1 = x^y, b1 = ~x&y;
  - second half subtractor: d = d1^c, b2 = ~d1&c;
  - borrow ← b1|b2;
  - sa and sb shift right by one;
  - the result shift register shifts right, inserting d at the MSB.
- When counter = WIDTH−1 on a RUN edge:
  - diff ← final result register value;
  - bout ← final borrow;
  - state ← DONE.
- Otherwise the counter increments. The counter is $clog2(WIDTH) bits wide and never wraps during an operation.
- start while in RUN is ignored: no restart, and the in-flight operation is unaffected.
- a, b and bin are don't-care except on the accepting edge.
- Arithmetic: diff = (a − b − seed) mod 2^WIDTH; bout = 1 iff a < b + seed, evaluated as a (WIDTH+1)-bit unsigned compare.
- Reset at any time, including mid-RUN:
  - aborts the operation immediately and asynchronously;
  - clears all state and shift registers;
  - no done pulse is produced for the aborted operation.

## Timing
- Reset values: diff=0, bout=0, busy=0, done=0, state=IDLE.
- Accepting edge E0 → busy=1 from E0 through edge E(WIDTH).
- At edge E(WIDTH): busy=0, done=1, diff/bout valid.
- At edge E(WIDTH+1): done=0. diff/bout hold.
- Latency: WIDTH+1 cycles from the start edge to the first cycle where done=1.
- Back-to-back: start held or re-asserted while done=1 is accepted on E(WIDTH+1). That edge clears diff/bout and busy rises again, giving a sustained rate of one result per WIDTH+1 cycles.
- done and busy are never high simultaneously.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_BORROW_IN_EN defined:
  - the bin port exists;
  - bin is sampled on the accepting edge and seeds the borrow flop;
  - this allows chaining for multi-word subtraction.
- Not defined:
  - no bin port;
  - the borrow flop is seeded with 0;
  - the block computes plain a − b.
- All other behaviour and timing are identical in both builds.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, start one cycle → done exactly 9 cycles later; diff=0x37, bout=0; busy high for 8 cycles.
- a=0x10, b=0x20 → diff=0xF0, bout=1. a=0x00, b=0x00 → diff=0x00, bout=0. a=0xFF, b=0x01 → diff=0xFE, bout=0.
- Start re-pulsed in the 3rd RUN cycle with a=0x00, b=0xFF during a 0x5A−0x23 operation → ignored; result is still 0x37, bout=0, and only one done pulse occurs.
- Assert rst in the 4th RUN cycle → all outputs 0 immediately and no done pulse. A new start of 0x80−0x01 after release → diff=0x7F, bout=0.
- Start held high continuously with operands 0x05−0x03, then 0x03−0x05 → done every 9 cycles; results 0x02/bout=0, then 0xFE/bout=1.
- With SERIAL_SUB_BORROW_IN_EN: a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1. a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
